// File: rtl/npu_pkg.sv
// ============================================================================
// npu_pkg - shared widths and constants for the NPU datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

package npu_pkg;

    localparam int MAC_W      = 16;
    localparam int BYTE_W     = 8;
    localparam int PISO_W     = 2 * MAC_W;
    localparam int PISO_BYTES = PISO_W / BYTE_W;
    localparam int CNT_W      = $clog2(PISO_BYTES + 1);

endpackage : npu_pkg

`default_nettype wire

// File: rtl/piso_out.sv
// ============================================================================
// piso_out - captures {mac0_out, mac1_out} and streams it MSB byte first on D_OUT
// Revision: 1.0
// ============================================================================
`default_nettype none

module piso_out
    import npu_pkg::*;
(
    input  logic              CLKEXT,
    input  logic              RST_GLO,
    input  logic              EN_PISO_OUT,
    input  logic              CLR_PISO_OUT,
    input  logic              SHIFT_OUT,
    input  logic [MAC_W-1:0]  mac0_out,
    input  logic [MAC_W-1:0]  mac1_out,
    output logic [BYTE_W-1:0] D_OUT
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PISO_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [PISO_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;

    // Clear outranks enable; once the word is drained the register keeps
    // shifting its zero fill, so extra shifts naturally present 8'h00.
    always_ff @(posedge CLKEXT or negedge RST_GLO) begin
        if (!RST_GLO) begin
            sreg  <= '0;
            cnt   <= '0;
            D_OUT <= '0;
        end else if (CLR_PISO_OUT) begin
            sreg  <= '0;
            cnt   <= '0;
            D_OUT <= '0;
        end else if (EN_PISO_OUT) begin
            if (!SHIFT_OUT) begin
                sreg <= {mac0_out, mac1_out};
                cnt  <= CNT_FULL;
            end else begin
                D_OUT <= sreg[PISO_W-1 -: BYTE_W];
                sreg  <= {sreg[PISO_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                if (cnt != '0) begin
                    cnt <= cnt - CNT_ONE;
                end
            end
        end
    end

endmodule : piso_out

`default_nettype wire

// File: tb/tb_piso_out.sv
// ============================================================================
// tb_piso_out - directed self-checking bench for piso_out
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_piso_out;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        shift;
    logic [15:0] mac0;
    logic [15:0] mac1;
    logic [7:0]  d_out;

    int checks = 0;
    int errors = 0;

    piso_out dut (
        .CLKEXT       (clk),
        .RST_GLO      (rst_n),
        .EN_PISO_OUT  (en),
        .CLR_PISO_OUT (clr),
        .SHIFT_OUT    (shift),
        .mac0_out     (mac0),
        .mac1_out     (mac1),
        .D_OUT        (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Apply controls, take one rising edge, then settle away from the edge.
    task automatic step(input logic e, input logic s, input logic c);
        en    = e;
        shift = s;
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b);
        mac0 = a;
        mac1 = b;
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic shift_expect(input string tag, input logic [7:0] exp);
        step(1'b1, 1'b1, 1'b0);
        check(tag, d_out, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        shift = 1'b0;
        mac0  = '0;
        mac1  = '0;

        // Reset held with random activity on the inputs
        for (int i = 0; i < 2; i++) begin
            mac0  = 16'($urandom);
            mac1  = 16'($urandom);
            en    = 1'($urandom);
            shift = 1'($urandom);
            clr   = 1'($urandom);
            @(posedge clk);
            #1;
            check("reset_hold", d_out, 8'h00);
        end
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        check("post_reset_idle0", d_out, 8'h00);
        step(1'b0, 1'b0, 1'b0);
        check("post_reset_idle1", d_out, 8'h00);

        // AAAA/5555 plus an overrun shift
        load(16'hAAAA, 16'h5555);
        check("load_no_change", d_out, 8'h00);
        shift_expect("aa_b0", 8'hAA);
        shift_expect("aa_b1", 8'hAA);
        shift_expect("aa_b2", 8'h55);
        shift_expect("aa_b3", 8'h55);
        shift_expect("aa_over", 8'h00);

        // 1234/ABCD then back-to-back FFFF/0000
        load(16'h1234, 16'hABCD);
        shift_expect("w1_b0", 8'h12);
        shift_expect("w1_b1", 8'h34);
        shift_expect("w1_b2", 8'hAB);
        shift_expect("w1_b3", 8'hCD);
        load(16'hFFFF, 16'h0000);
        check("b2b_load_hold", d_out, 8'hCD);
        shift_expect("w2_b0", 8'hFF);
        shift_expect("w2_b1", 8'hFF);
        shift_expect("w2_b2", 8'h00);
        shift_expect("w2_b3", 8'h00);

        // Reload mid-word discards the old bytes
        load(16'h1234, 16'hABCD);
        shift_expect("rl_b0", 8'h12);
        shift_expect("rl_b1", 8'h34);
        load(16'hFFFF, 16'h0000);
        check("reload_hold", d_out, 8'h34);
        shift_expect("rl_n0", 8'hFF);
        shift_expect("rl_n1", 8'hFF);
        shift_expect("rl_n2", 8'h00);
        shift_expect("rl_n3", 8'h00);

        // Clear together with shift, then with enable low
        load(16'h1234, 16'hABCD);
        shift_expect("clr_b0", 8'h12);
        step(1'b1, 1'b1, 1'b1);
        check("clr_wins", d_out, 8'h00);
        shift_expect("clr_after0", 8'h00);
        shift_expect("clr_after1", 8'h00);
        load(16'hBEEF, 16'hCAFE);
        shift_expect("clr_reload", 8'hBE);
        step(1'b0, 1'b1, 1'b1);
        check("clr_no_en", d_out, 8'h00);
        shift_expect("clr_no_en_after", 8'h00);

        // Enable low freezes the stream; MAC changes are ignored while not loading
        load(16'h1234, 16'hABCD);
        shift_expect("en_b0", 8'h12);
        mac0 = 16'h9999;
        mac1 = 16'h7777;
        step(1'b0, 1'b1, 1'b0);
        check("en_freeze0", d_out, 8'h12);
        step(1'b0, 1'b0, 1'b0);
        check("en_freeze1", d_out, 8'h12);
        shift_expect("en_b1", 8'h34);
        shift_expect("en_b2", 8'hAB);
        shift_expect("en_b3", 8'hCD);

        // Asynchronous reset mid-stream
        load(16'h5A5A, 16'hC3C3);
        shift_expect("ar_b0", 8'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", d_out, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        shift_expect("ar_after", 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_piso_out

`default_nettype wire
